// File: rtl/mod_m_counter_prog.sv
// mod_m_counter_prog -- programmable-modulus up/down counter.
//
// Counts 0..term_reg (modulus = term_reg+1) up or down. The terminal value
// is shadowed: term_in is only captured on clr, load or wrap, so a new
// modulus never cuts short a period already in progress. In one-shot mode
// the counter halts at its terminal value until cleared, loaded or reset.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        count enable
//   up        1 = count up, 0 = count down
//   oneshot   1 = halt at terminal instead of wrapping
//   clr       synchronous clear (highest priority)
//   load      synchronous load of min(load_val, term_in)
//   load_val  load value
//   term_in   requested terminal value (modulus-1)
//   q         count
//   max_tick  q == term_reg
//   min_tick  q == 0
//   carry     terminal event this cycle (combinational, for cascading)
//   done      one-shot halted (registered)
module mod_m_counter_prog #(
  parameter int W     = 4,
  parameter int M_RST = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_in,
  output logic [W-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         carry,
  output logic         done
);

  // M_RST may be 2^W, so M_RST-1 is formed in int and then truncated.
  localparam logic [W-1:0] TERM_RST = W'(M_RST - 1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t       state, state_n;
  logic [W-1:0] term_reg, term_n;
  logic [W-1:0] q_n;
  logic         t_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q        <= '0;
      term_reg <= TERM_RST;
      state    <= RUN;
    end else begin
      q        <= q_n;
      term_reg <= term_n;
      state    <= state_n;
    end
  end

  // Terminal condition follows the current direction input.
  assign t_hit = up ? (q == term_reg) : (q == '0);

  always_comb begin
    q_n     = q;
    term_n  = term_reg;
    state_n = state;
    if (clr) begin
      q_n     = '0;
      term_n  = term_in;
      state_n = RUN;
    end else if (load) begin
      // Loads above the new terminal value saturate to it.
      q_n     = (load_val > term_in) ? term_in : load_val;
      term_n  = term_in;
      state_n = RUN;
    end else if (en && state == RUN) begin
      if (!t_hit) begin
        q_n = up ? q + 1'b1 : q - 1'b1;
      end else if (!oneshot) begin
        // Wrap: this is the only point where a mid-count term_in lands.
        q_n    = up ? '0 : term_in;
        term_n = term_in;
      end else begin
        state_n = HALT;
      end
    end
  end

  assign max_tick = (q == term_reg);
  assign min_tick = (q == '0);
  assign done     = (state == HALT);
  assign carry    = reset & en & (state == RUN) & t_hit & ~clr & ~load;

endmodule

// File: tb/tb_mod_m_counter_prog.sv
module tb_mod_m_counter_prog;

  localparam int W     = 4;
  localparam int M_RST = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0, up = 1'b1, oneshot = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0, term_in = 4'd9;
  logic [W-1:0] q;
  logic         max_tick, min_tick, carry, done;

  mod_m_counter_prog #(.W(W), .M_RST(M_RST)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .oneshot(oneshot),
    .clr(clr), .load(load), .load_val(load_val), .term_in(term_in),
    .q(q), .max_tick(max_tick), .min_tick(min_tick), .carry(carry),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic         mx, mn, cy, dn;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 0;

  // Reference model: count, current terminal, halted flag, plain ints.
  int m_count = 0;
  int m_term  = M_RST - 1;
  bit m_halt  = 0;

  function automatic bit terminal();
    return up ? (m_count == m_term) : (m_count == 0);
  endfunction

  // Apply one cycle of inputs at the falling edge, record what the outputs
  // must show before the next rising edge, then advance the model.
  task automatic drive(input bit r, input bit e, input bit u, input bit os,
                       input bit c, input bit l, input int lv, input int ti);
    obs_t x;
    int   nxt;
    @(negedge clk);
    reset = r; en = e; up = u; oneshot = os; clr = c; load = l;
    load_val = W'(lv); term_in = W'(ti);
    if (!r) begin
      m_count = 0; m_term = M_RST - 1; m_halt = 0;
    end
    x.q  = W'(m_count);
    x.mx = (m_count == m_term);
    x.mn = (m_count == 0);
    x.cy = r && e && !m_halt && terminal() && !c && !l;
    x.dn = m_halt;
    exp_q.push_back(x);
    if (!r) return;
    if (c) begin
      m_count = 0; m_term = ti; m_halt = 0;
    end else if (l) begin
      m_count = (lv < ti) ? lv : ti; m_term = ti; m_halt = 0;
    end else if (e && !m_halt) begin
      if (terminal() && os) m_halt = 1;
      else begin
        nxt = up ? m_count + 1 : m_count - 1;
        if (nxt > m_term || nxt < 0) begin
          m_term  = ti;
          m_count = up ? 0 : ti;
        end else m_count = nxt;
      end
    end
  endtask

  // Monitor: outputs are always presented, so one check per driven cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{q: q, mx: max_tick, mn: min_tick, cy: carry, dn: done};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t: actual q=%0d max=%b min=%b carry=%b done=%b, required q=%0d max=%b min=%b carry=%b done=%b",
                   vectors, $time, a.q, a.mx, a.mn, a.cy, a.dn,
                   e.q, e.mx, e.mn, e.cy, e.dn);
        end
      end
    end
  end

  initial begin
    // Reset held, then free-run modulus 10 for 25 cycles.
    drive(0, 1, 1, 0, 0, 0, 0, 9);
    drive(0, 1, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 25; i++) drive(1, 1, 1, 0, 0, 0, 0, 9);
    // Shadow modulus: reach q=3 then request term 4; lands only at the wrap.
    drive(1, 1, 1, 0, 1, 0, 0, 9);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 0, 0, 9);
    for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0, 0, 0, 4);
    // Down count from load 2 with term 6.
    drive(1, 0, 1, 0, 0, 1, 2, 6);
    for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 0, 0, 0, 6);
    // One-shot to 3, then halt, en ignored, then restart with a load.
    drive(1, 1, 1, 1, 1, 0, 0, 3);
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 1, 0, 0, 0, 3);
    drive(1, 1, 1, 1, 0, 1, 1, 3);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0, 0, 0, 3);
    // Priority and saturation.
    drive(1, 1, 1, 0, 1, 1, 5, 7);
    drive(1, 1, 1, 0, 0, 1, 15, 7);
    drive(1, 0, 1, 0, 0, 0, 0, 7);
    // Modulus 1, both directions.
    drive(1, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, i[0], 0, 0, 0, 0, 0);
    // Modulus 16, natural wrap both ways.
    drive(1, 1, 1, 0, 1, 0, 0, 15);
    for (int i = 0; i < 18; i++) drive(1, 1, 1, 0, 0, 0, 0, 15);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 0, 0, 0, 15);
    // Async reset in HALT at q=6, then release and count.
    drive(1, 1, 1, 1, 1, 0, 0, 6);
    for (int i = 0; i < 9; i++) drive(1, 1, 1, 1, 0, 0, 0, 6);
    drive(0, 1, 1, 0, 0, 0, 0, 9);
    drive(1, 1, 1, 0, 0, 0, 0, 9);
    drive(1, 1, 1, 0, 0, 0, 0, 9);
    // Async reset in RUN at q=6.
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 0, 0, 9);
    drive(0, 1, 1, 0, 0, 0, 0, 9);
    drive(1, 1, 1, 0, 0, 0, 0, 9);
    drive(1, 1, 1, 0, 0, 0, 0, 9);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 29) == 0,
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 9);
    end
    stim_done = 1;
  end

  initial begin
    int guard = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual running, required finished");
    $fatal(1);
  end

endmodule
